// File: rtl/param_counter_if.sv
// param_counter_if: control and status bundle for param_counter
interface param_counter_if #(parameter int WIDTH = 8);
   logic             clear;
   logic             load;
   logic             enable;
   logic             up;
   logic [WIDTH-1:0] Data;
   logic [WIDTH-1:0] Q;
   logic             tc;
   logic             ovf;
   modport master (output clear, load, enable, up, Data, input Q, tc, ovf);
   modport slave (input clear, load, enable, up, Data, output Q, tc, ovf);
endinterface

// File: rtl/param_counter.sv
// param_counter: up/down counter with load, clear, wrap or saturate at 0 and MAX_VAL
module param_counter #(
   parameter int             WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = '1,
   parameter bit             SATURATE = 1'b0
) (
   input logic             clk,
   input logic             reset,
   param_counter_if.slave  bus
);
   logic [WIDTH-1:0] q_nxt;
   logic             ovf_nxt;
   assign bus.tc = bus.enable & ((bus.up & (bus.Q == MAX_VAL)) | (~bus.up & (bus.Q == '0)));
   // next count: clear > load (clamped) > enabled step, boundary wraps or holds
   always_comb begin
      q_nxt   = bus.clear ? '0 :
                bus.load ? ((bus.Data > MAX_VAL) ? MAX_VAL : bus.Data) :
                !bus.enable ? bus.Q :
                bus.tc ? (SATURATE ? bus.Q : (bus.up ? '0 : MAX_VAL)) :
                bus.up ? bus.Q + 1'b1 : bus.Q - 1'b1;
      ovf_nxt = !bus.clear && !bus.load && bus.tc;
   end
   // count and boundary-pulse registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.Q   <= '0;
         bus.ovf <= 1'b0;
      end else begin
         bus.Q   <= q_nxt;
         bus.ovf <= ovf_nxt;
      end
   end
endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 The block SHALL provide parameter MAX_VAL, default 2**WIDTH-1: terminal count value, legal range 1..2**WIDTH-1.
REQ-003 The block SHALL provide parameter SATURATE, default 0: 0 selects wrap at the bounds, 1 selects hold at the bounds.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous clear to 0.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load from Data.
REQ-008 The block SHALL have port enable, input, 1 bit: count enable.
REQ-009 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-010 The block SHALL have port Data, input, WIDTH bits: load value.
REQ-011 The block SHALL have port Q, output, WIDTH bits: registered count.
REQ-012 The block SHALL have port tc, output, 1 bit: combinational terminal-count indicator.
REQ-013 The block SHALL have port ovf, output, 1 bit: registered one-cycle boundary-event pulse.

Function
REQ-014 Q SHALL update only on the rising clk edge, with one cycle of latency from the sampled controls.
REQ-015 Control priority per edge SHALL be clear > load > enable > hold.
REQ-016 On clear: Q SHALL become 0 and ovf SHALL become 0, regardless of load, enable and up.
REQ-017 On load: Q SHALL become min(Data, MAX_VAL), i.e. an out-of-range Data value is clamped to MAX_VAL; ovf SHALL become 0.
REQ-018 On enable with up=1 and Q<MAX_VAL: Q SHALL become Q+1.
REQ-019 On enable with up=0 and Q>0: Q SHALL become Q-1.
REQ-020 On enable with up=1 and Q==MAX_VAL: Q SHALL become 0 when SATURATE=0, or hold MAX_VAL when SATURATE=1; ovf SHALL be 1 in the following cycle.
REQ-021 On enable with up=0 and Q==0: Q SHALL become MAX_VAL when SATURATE=0, or hold 0 when SATURATE=1; ovf SHALL be 1 in the following cycle.
REQ-022 ovf SHALL be 0 after any edge that is not a boundary event, so that each boundary event gives a single-cycle pulse; back-to-back boundary events in saturate mode SHALL keep ovf high on each such cycle.
REQ-023 tc SHALL equal enable & ((up & Q==MAX_VAL) | (~up & Q==0)); tc SHALL NOT depend on clear or load.
REQ-024 With enable=0 and no clear or load: Q SHALL hold and ovf SHALL be 0.
REQ-025 Q SHALL never exceed MAX_VAL under any input sequence; arithmetic SHALL be WIDTH bits wide with no carry-out port.
REQ-026 Changing up while enable=1 SHALL take effect on the next edge, with no dead cycle.

Reset
REQ-027 reset=0 SHALL force Q=0 and ovf=0 immediately, without waiting for a clk edge, including mid-count.
REQ-028 While reset=0, all other inputs SHALL be ignored.
REQ-029 The first rising edge with reset=1 SHALL apply normal priority; if enable=1, up=1 is sampled on that edge, Q SHALL become 1.

Verification
REQ-030 Defaults; load Data=0x55, then enable=1, up=1 for 5 edges -> Q=0x5A, ovf=0 throughout.
REQ-031 Defaults; load 0xFE, enable=1, up=1 for 3 edges -> Q=0xFF, then 0x00, then 0x01; tc=1 while Q=0xFF; ovf=1 only in the cycle in which Q=0x00.
REQ-032 Defaults; load 0x01, enable=1, up=0 for 2 edges -> Q=0x00, then 0xFF with ovf pulse; repeat with SATURATE=1 -> Q holds 0x00 and ovf stays 1 for each further enabled edge.
REQ-033 WIDTH=8, MAX_VAL=99; load Data=0xC8 -> Q=0x63; then enable up -> Q=0x00 with ovf pulse.
REQ-034 clear=1, load=1 and enable=1 on the same edge with Q=0x37 -> Q=0x00; load=1 with enable=1 and Data=0x10 -> Q=0x10, not 0x11.
REQ-035 Count to 0x37, then drive reset=0 between clk edges -> Q=0x00 and ovf=0 before the next edge; release reset with enable=1, up=1 -> Q=0x01 after the first edge.
